// File: rtl/mcu_pkg.sv
// Shared MCU definitions: block-transfer sequencer state encoding and
// architectural constants.
package mcu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } seq_state_t;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/lsb_index16.sv
// Lowest-set-bit priority encoder over a 16-bit vector; 'none' flags an
// all-zero input (idx is then 0).
module lsb_index16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        none
);

  // Scan downwards so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    idx  = 4'd0;
    none = (vec == 16'd0);
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list one memory beat
// per register, then optionally writes the updated base back.
module ldm_stm_sequencer
  import mcu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic [15:0]       reg_list,
  output logic [3:0]        rf_ra,
  input  logic [ADDR_W-1:0] rf_rd,
  output logic [3:0]        rf_wa,
  output logic [ADDR_W-1:0] rf_wd,
  output logic              rf_we,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_wd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  seq_state_t        state, state_nxt;
  logic              is_load_q;
  logic              skip_wb_q;
  logic [3:0]        base_reg_q;
  logic [15:0]       list_q;
  logic [15:0]       list_rem;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] final_q;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] base_al;
  logic [ADDR_W-1:0] start_addr;
  logic [4:0]        n_cnt;
  logic [3:0]        cur_idx;
  logic              cur_none;
  logic              last_beat;

  lsb_index16 u_lsb (
    .vec  (list_q),
    .idx  (cur_idx),
    .none (cur_none)
  );

  always_comb begin
    n_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n_cnt = n_cnt + 5'(reg_list[i]);
    end
    span    = ADDR_W'(n_cnt) * STEP;
    base_al = {base_val[ADDR_W-1:2], 2'b00};
    unique case ({up, pre})
      2'b10:   start_addr = base_al;
      2'b11:   start_addr = base_al + STEP;
      2'b00:   start_addr = base_al - span + STEP;
      default: start_addr = base_al - span;
    endcase
    list_rem  = list_q & ~(16'd1 << cur_idx);
    last_beat = cur_none || (list_rem == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_load_q  <= 1'b0;
      skip_wb_q  <= 1'b0;
      base_reg_q <= 4'd0;
      list_q     <= 16'd0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        is_load_q  <= is_load;
        // R15 is never written through rf_we, and a loaded base wins over writeback.
        skip_wb_q  <= !wback || (base_reg == REG_PC) || (is_load && reg_list[base_reg]);
        base_reg_q <= base_reg;
        list_q     <= reg_list;
        addr_q     <= start_addr;
        final_q    <= up ? (base_val + span) : (base_val - span);
      end else if (state == XFER && mem_ready) begin
        list_q <= list_rem;
        addr_q <= addr_q + STEP;
      end
    end
  end

  // Outputs are gated by rst so a reset drops mem_req in the same cycle.
  always_comb begin
    state_nxt = state;
    rf_ra     = 4'd0;
    rf_wa     = 4'd0;
    rf_wd     = '0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (start) state_nxt = (reg_list == 16'd0) ? DONE : XFER;
        end
        XFER: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_addr = addr_q;
          mem_we   = !is_load_q;
          if (!is_load_q) begin
            rf_ra     = cur_idx;
            mem_wdata = rf_rd;
          end
          if (mem_ready) begin
            if (is_load_q) begin
              if (cur_idx == REG_PC) begin
                pc_we = 1'b1;
                pc_wd = mem_rdata;
              end else begin
                rf_we = 1'b1;
                rf_wa = cur_idx;
                rf_wd = mem_rdata;
              end
            end
            if (last_beat) state_nxt = skip_wb_q ? DONE : WB;
          end
        end
        WB: begin
          busy      = 1'b1;
          rf_we     = 1'b1;
          rf_wa     = base_reg_q;
          rf_wd     = final_q;
          state_nxt = DONE;
        end
        DONE: begin
          busy      = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed transfers push expected
// events; a negedge monitor pops and compares whatever the DUT presents.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, up, pre, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, pc_wd, mem_addr, mem_wdata, mem_rdata;
  logic        rf_we, pc_we, mem_req, mem_we, mem_ready, busy, done;

  typedef enum int {EV_BEAT, EV_RF, EV_PC, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  r;
    logic        we;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  mon_rel;
  int  wait_states = 0;
  int  ws_cnt = 0;
  bit  mon_en = 0;
  bit  done_seen = 0;
  logic        prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .wback     (wback),
    .base_reg  (base_reg),
    .base_val  (base_val),
    .reg_list  (reg_list),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  // Register file returns a tagged value; memory returns a scrambled address.
  assign rf_rd     = 32'hA000_0000 | {28'd0, rf_ra};
  assign mem_rdata = mem_addr ^ 32'h5A00_0000;
  assign mem_ready = mem_req && (ws_cnt >= wait_states);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !mem_req || mem_ready) ws_cnt <= 0;
    else ws_cnt <= ws_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input ev_kind_t k, input int c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] r, input logic we);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d; e.r = r; e.we = we;
    sb.push_back(e);
  endtask

  task automatic expectEvent(input ev_kind_t k, input int rel);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_event kind=%0d cycle=%0d", k, rel);
    end else begin
      e = sb.pop_front();
      checkOutput("event_kind", 32'(k), 32'(e.kind));
      checkOutput("event_cycle", 32'(rel), 32'(e.cyc));
      case (k)
        EV_BEAT: begin
          checkOutput("mem_addr", mem_addr, e.a);
          checkOutput("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) begin
            checkOutput("mem_wdata", mem_wdata, e.d);
            checkOutput("rf_ra", 32'(rf_ra), 32'(e.r));
          end
        end
        EV_RF: begin
          checkOutput("rf_wa", 32'(rf_wa), 32'(e.r));
          checkOutput("rf_wd", rf_wd, e.d);
        end
        EV_PC: checkOutput("pc_wd", pc_wd, e.d);
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    mon_rel = cyc - t0 + 1;
    if (mon_en && !rst) begin
      if (prev_wait && mem_req) begin
        checkOutput("hold_addr", mem_addr, prev_addr);
        checkOutput("hold_we", 32'(mem_we), 32'(prev_we));
        checkOutput("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ready) expectEvent(EV_BEAT, mon_rel);
      if (pc_we) expectEvent(EV_PC, mon_rel);
      if (rf_we) expectEvent(EV_RF, mon_rel);
      if (done) begin
        expectEvent(EV_DONE, mon_rel);
        done_seen = 1;
      end
    end
    prev_wait  = mem_req && !mem_ready;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  task automatic checkIdleZero(input string name);
    checkOutput({name, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
    checkOutput({name, "_rf_we"}, 32'(rf_we), 32'd0);
    checkOutput({name, "_pc_we"}, 32'(pc_we), 32'd0);
    checkOutput({name, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({name, "_rf_wa"}, 32'(rf_wa), 32'd0);
    checkOutput({name, "_rf_wd"}, rf_wd, 32'd0);
    checkOutput({name, "_pc_wd"}, pc_wd, 32'd0);
    checkOutput({name, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Launch one instruction, optionally re-pulse start while busy, wait for done.
  task automatic applyStimulus(input logic ld, input logic u, input logic p, input logic wb,
                               input logic [3:0] br, input logic [31:0] base,
                               input logic [15:0] list, input int ws, input int restart);
    wait_states = ws;
    done_seen   = 0;
    @(posedge clk); #1;
    is_load = ld; up = u; pre = p; wback = wb;
    base_reg = br; base_val = base; reg_list = list; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == restart) begin
        start    = 1'b1;
        reg_list = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_seen) break;
    end
    start = 1'b0;
    if (!done_seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=0 required=1");
    end
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=expired required=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    base_reg = 4'd0; base_val = 32'd0; reg_list = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkIdleZero("reset");
    mon_en = 1;

    $display("[TB] STM IA R1-R3");
    pushExp(EV_BEAT, 1, 32'h100, 32'hA000_0001, 4'd1, 1'b1);
    pushExp(EV_BEAT, 2, 32'h104, 32'hA000_0002, 4'd2, 1'b1);
    pushExp(EV_BEAT, 3, 32'h108, 32'hA000_0003, 4'd3, 1'b1);
    pushExp(EV_DONE, 4, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h100, 16'h000E, 0, 0);

    $display("[TB] LDM DB writeback R0,R4");
    pushExp(EV_BEAT, 1, 32'h1F8, 32'h0, 4'd0, 1'b0);
    pushExp(EV_RF,   1, 32'h0, 32'h5A00_01F8, 4'd0, 1'b0);
    pushExp(EV_BEAT, 2, 32'h1FC, 32'h0, 4'd0, 1'b0);
    pushExp(EV_RF,   2, 32'h0, 32'h5A00_01FC, 4'd4, 1'b0);
    pushExp(EV_RF,   3, 32'h0, 32'h0000_01F8, 4'd1, 1'b0);
    pushExp(EV_DONE, 4, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h200, 16'h0011, 0, 0);

    $display("[TB] LDM IB R0,PC with wait states");
    pushExp(EV_BEAT, 2, 32'h404, 32'h0, 4'd0, 1'b0);
    pushExp(EV_RF,   2, 32'h0, 32'h5A00_0404, 4'd0, 1'b0);
    pushExp(EV_BEAT, 4, 32'h408, 32'h0, 4'd0, 1'b0);
    pushExp(EV_PC,   4, 32'h0, 32'h5A00_0408, 4'd0, 1'b0);
    pushExp(EV_DONE, 5, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h400, 16'h8001, 1, 0);

    $display("[TB] LDM writeback with base in list");
    pushExp(EV_BEAT, 1, 32'h500, 32'h0, 4'd0, 1'b0);
    pushExp(EV_RF,   1, 32'h0, 32'h5A00_0500, 4'd2, 1'b0);
    pushExp(EV_DONE, 2, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h500, 16'h0004, 0, 0);

    $display("[TB] empty list with writeback");
    pushExp(EV_DONE, 1, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h600, 16'h0000, 0, 0);

    $display("[TB] STM DA writeback, start re-pulsed while busy");
    pushExp(EV_BEAT, 1, 32'h7FC, 32'hA000_0001, 4'd1, 1'b1);
    pushExp(EV_BEAT, 2, 32'h800, 32'hA000_0002, 4'd2, 1'b1);
    pushExp(EV_RF,   3, 32'h0, 32'h0000_07F8, 4'd2, 1'b0);
    pushExp(EV_DONE, 4, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h800, 16'h0006, 0, 2);

    $display("[TB] LDM writeback to base R15 is skipped");
    pushExp(EV_BEAT, 1, 32'h900, 32'h0, 4'd0, 1'b0);
    pushExp(EV_RF,   1, 32'h0, 32'h5A00_0900, 4'd1, 1'b0);
    pushExp(EV_DONE, 2, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 32'h900, 16'h0002, 0, 0);

    $display("[TB] reset during second beat of STM");
    wait_states = 0;
    pushExp(EV_BEAT, 1, 32'h300, 32'hA000_0004, 4'd4, 1'b1);
    @(posedge clk); #1;
    is_load = 1'b0; up = 1'b1; pre = 1'b0; wback = 1'b0;
    base_reg = 4'd0; base_val = 32'h300; reg_list = 16'h00F0; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    @(posedge clk); #1;
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_scoreboard", 32'(sb.size()), 32'd0);
    checkIdleZero("after_rst");
    sb.delete();
    mon_en = 1;

    $display("[TB] STM IB after reset");
    pushExp(EV_BEAT, 1, 32'h1004, 32'hA000_0000, 4'd0, 1'b1);
    pushExp(EV_BEAT, 2, 32'h1008, 32'hA000_0008, 4'd8, 1'b1);
    pushExp(EV_DONE, 3, 32'h0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h1000, 16'h0101, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
